mem_arbiter_nch: RTL

- Arbitrates cache-line refill/write-back traffic from NUM_CH cache controllers (I-cache, D-cache, future L1 instances) onto a single shared slow-memory port.
- Lets one off-chip memory serve all caches, replacing the separate I/D memory ports.
- Sits between the cache memory-side ports and the memory interface at chip top.
- Modes: round-robin or fixed-priority arbitration, selected by parameter.

---
 rtl/mem_arbiter_nch_if.sv | 46 ++++
 rtl/mem_arbiter_nch.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_nch_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_nch_if
// Bundles the cache-side and memory-side signals of mem_arbiter_nch.
//
//   slave  modport : the arbiter itself
//     in : ch_read, ch_write, ch_addr, ch_wdata  (per-channel requests)
//          mem_rdata, mem_ready                  (memory completion)
//     out: ch_rdata, ch_ready                    (shared line, one-hot done)
//          mem_read, mem_write, mem_addr, mem_wdata
//          busy, grant_id
//   master modport : the surrounding caches + memory (mirror of slave)
// ---------------------------------------------------------------------------
interface mem_arbiter_nch_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
);
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*LINE_W-1:0] ch_wdata;
  logic [LINE_W-1:0]        ch_rdata;
  logic [NUM_CH-1:0]        ch_ready;
  logic                     mem_read;
  logic                     mem_write;
  logic [ADDR_W-1:0]        mem_addr;
  logic [LINE_W-1:0]        mem_wdata;
  logic [LINE_W-1:0]        mem_rdata;
  logic                     mem_ready;
  logic                     busy;
  logic [ID_W-1:0]          grant_id;

  modport slave (
    input  ch_read, ch_write, ch_addr, ch_wdata, mem_rdata, mem_ready,
    output ch_rdata, ch_ready, mem_read, mem_write, mem_addr, mem_wdata,
           busy, grant_id
  );

  modport master (
    output ch_read, ch_write, ch_addr, ch_wdata, mem_rdata, mem_ready,
    input  ch_rdata, ch_ready, mem_read, mem_write, mem_addr, mem_wdata,
           busy, grant_id
  );
endinterface

// File: rtl/mem_arbiter_nch.sv
// ---------------------------------------------------------------------------
// mem_arbiter_nch
// Shares one slow line-wide memory port between NUM_CH cache controllers.
// A three-state FSM (IDLE -> GRANT -> RESP) serves one line transfer at a
// time; the winner is chosen round-robin (PRIO_MODE=0) or by fixed priority
// with channel 0 highest (PRIO_MODE=1). All outputs are registered.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mem_arbiter_nch_if.slave (cache requests, memory strobes,
//            shared read line, one-hot ch_ready, busy, grant_id)
// ---------------------------------------------------------------------------
module mem_arbiter_nch #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 28,
  parameter int LINE_W    = 128,
  parameter int PRIO_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_arbiter_nch_if.slave   bus
);

  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_gid;
  logic                r_read;
  logic                r_write;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic [LINE_W-1:0]   r_rdata;
  logic [NUM_CH-1:0]   r_ready;

  logic [NUM_CH-1:0]   w_req;
  logic                w_any;
  logic [ID_W-1:0]     w_win;
  logic                w_win_wr;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [LINE_W-1:0]   w_win_wdata;

  assign w_req = bus.ch_read | bus.ch_write;
  assign w_any = |w_req;

  // Winner search. Round-robin starts one past the last winner and wraps,
  // so the channel just served is considered last; fixed priority simply
  // takes the lowest index.
  always_comb begin : winner_sel
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    w_win = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (PRIO_MODE == 0) begin
        idx = (int'(r_ptr) + k) % NUM_CH;
      end else begin
        idx = k - 1;
      end
      if (!found && w_req[idx]) begin
        found = 1'b1;
        w_win = ID_W'(idx);
      end
    end
  end

  // A simultaneous read+write from one channel is treated as a write.
  always_comb begin : winner_fields
    w_win_wr    = bus.ch_write[w_win];
    w_win_addr  = bus.ch_addr[w_win*ADDR_W +: ADDR_W];
    w_win_wdata = bus.ch_wdata[w_win*LINE_W +: LINE_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      // Pointer at the top channel so the first round-robin scan starts at 0.
      r_ptr   <= ID_W'(NUM_CH - 1);
      r_gid   <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_busy  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            // Latch everything now; ch_* may change freely during GRANT.
            r_gid   <= w_win;
            r_write <= w_win_wr;
            r_read  <= ~w_win_wr;
            r_addr  <= w_win_addr;
            r_wdata <= w_win_wdata;
            r_busy  <= 1'b1;
            if (PRIO_MODE == 0) begin
              r_ptr <= w_win;
            end
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          // No timeout: the memory is trusted to answer eventually.
          if (bus.mem_ready) begin
            if (r_read) begin
              r_rdata <= bus.mem_rdata;
            end
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_ready <= NUM_CH'(1) << r_gid;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          // The served channel still shows its request here; going straight
          // back to IDLE keeps it from being granted twice off one request.
          r_ready <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_read  = r_read;
  assign bus.mem_write = r_write;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.ch_rdata  = r_rdata;
  assign bus.ch_ready  = r_ready;
  assign bus.busy      = r_busy;
  assign bus.grant_id  = r_gid;

endmodule
